// File: rtl/graphing_hw_pkg.sv
// Shared types for the 2D geometry hardware layer: coordinates, points and
// the rasterizer control states.
package graphing_hw_pkg;

  localparam int COORD_W = 16;

  typedef logic signed [COORD_W-1:0] coord_t;

  typedef struct packed {
    coord_t x;
    coord_t y;
  } point2d_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    STEP  = 2'd2
  } rast_state_t;

endpackage

// File: rtl/line2d_rasterizer.sv
// Bresenham line rasterizer: takes one segment (two signed endpoints) and
// streams every grid point on it, endpoints included, one point per cycle.
module line2d_rasterizer #(
  parameter int COORD_W = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic signed [COORD_W-1:0] in_x0,
  input  logic signed [COORD_W-1:0] in_y0,
  input  logic signed [COORD_W-1:0] in_x1,
  input  logic signed [COORD_W-1:0] in_y1,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic signed [COORD_W-1:0] out_x,
  output logic signed [COORD_W-1:0] out_y,
  output logic                      out_last,
  output logic                      busy
);
  import graphing_hw_pkg::*;

  // Differences and the error term need two extra bits so a full-range
  // span cannot overflow; 2*err needs one more.
  localparam int DW = COORD_W + 2;
  localparam int EW = COORD_W + 3;

  rast_state_t               state;
  logic signed [COORD_W-1:0] x0_q, y0_q, x1_q, y1_q;
  logic signed [DW-1:0]      dx_q, dy_q, err_q;
  logic                      sx_neg, sy_neg;

  // in_ready is forced low in the reset cycle itself, high whenever idle.
  assign in_ready = (state == IDLE) && !rst;
  assign busy     = (state != IDLE);

  // Setup datapath: signed spans and their magnitudes.
  logic signed [DW-1:0] ddx, ddy, adx, ady;
  always_comb begin
    ddx = DW'(x1_q) - DW'(x0_q);
    ddy = DW'(y1_q) - DW'(y0_q);
    adx = ddx[DW-1] ? -ddx : ddx;
    ady = ddy[DW-1] ? -ddy : ddy;
  end

  // Step datapath: both axis decisions use the same e2.
  logic signed [EW-1:0]      e2;
  logic                      step_x, step_y;
  logic signed [DW-1:0]      err_nxt;
  logic signed [COORD_W-1:0] nx, ny;
  logic                      last_nxt;
  always_comb begin
    e2      = EW'(err_q) <<< 1;
    step_x  = (e2 >= EW'(dy_q));
    step_y  = (e2 <= EW'(dx_q));
    err_nxt = err_q;
    if (step_x) err_nxt = err_nxt + dy_q;
    if (step_y) err_nxt = err_nxt + dx_q;
    nx = out_x;
    ny = out_y;
    if (step_x) nx = sx_neg ? out_x - COORD_W'(1) : out_x + COORD_W'(1);
    if (step_y) ny = sy_neg ? out_y - COORD_W'(1) : out_y + COORD_W'(1);
    last_nxt = (nx == x1_q) && (ny == y1_q);
  end

  // Control FSM with registered point outputs; cur position lives in out_x/out_y.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_x     <= '0;
      out_y     <= '0;
      x0_q      <= '0;
      y0_q      <= '0;
      x1_q      <= '0;
      y1_q      <= '0;
      dx_q      <= '0;
      dy_q      <= '0;
      err_q     <= '0;
      sx_neg    <= 1'b0;
      sy_neg    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            x0_q  <= in_x0;
            y0_q  <= in_y0;
            x1_q  <= in_x1;
            y1_q  <= in_y1;
            state <= SETUP;
          end
        end
        SETUP: begin
          dx_q      <= adx;
          dy_q      <= -ady;
          err_q     <= adx - ady;
          sx_neg    <= ddx[DW-1];
          sy_neg    <= ddy[DW-1];
          out_x     <= x0_q;
          out_y     <= y0_q;
          out_last  <= (x0_q == x1_q) && (y0_q == y1_q);
          out_valid <= 1'b1;
          state     <= STEP;
        end
        STEP: begin
          if (out_ready) begin
            if (out_last) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              state     <= IDLE;
            end else begin
              err_q    <= err_nxt;
              out_x    <= nx;
              out_y    <= ny;
              out_last <= last_nxt;
            end
          end
        end
        default: begin
          out_valid <= 1'b0;
          out_last  <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
